fetch_queue: RTL and testbench

Consumer end of the program-counter/instruction-fetch interface. Takes the PC stream and its valid flag and drives the synchronous instruction memory. Captures the returned 16-bit Thumb instructions with their PCs into a small FIFO, which presents them to decode over a valid/ready handshake. Drives the stall signal back to the program counter so the PC holds whenever buffer space cannot be guaranteed; on a branch redirect, flushes all buffered and in-flight instructions.

---
 rtl/fetch_queue_pkg.sv | 24 ++
 rtl/fetch_queue_sync_fifo.sv | 85 ++++++++
 rtl/fetch_queue.sv | 102 ++++++++++
 tb/tb_fetch_queue.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// +--------------------------------------------------------------------------+
// | fetch_queue_pkg: shared types and widths for the fetch queue.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package fetch_queue_pkg;

  localparam int WORD      = 32;
  localparam int HALF_WORD = 16;

  typedef enum logic {
    NO_STALL       = 1'b0,
    STALL_PIPELINE = 1'b1
  } stall_pipeline_sig;

  typedef struct packed {
    logic [HALF_WORD-1:0] instr;
    logic [WORD-1:0]      pc;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_queue_sync_fifo.sv
// +--------------------------------------------------------------------------+
// | sync_fifo: single-clock FIFO with flush and occupancy count.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module sync_fifo
  import fetch_queue_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   push_i,
  input  entry_t                 data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output entry_t                 head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push_i && !flush_i;
    do_pop   = pop_i && !flush_i && (count_q != '0);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Upstream stall guarantees space, so a push while full is a design error.
  always_ff @(posedge clk_i) begin
    if (!reset_i && do_push) begin
      assert (count_q != CNT_W'(DEPTH));
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// +--------------------------------------------------------------------------+
// | fetch_queue: PC request tracking, stall generation and decode FIFO.      |
// | FETCH_QUEUE_BYPASS_EN: forward a response straight to decode when empty. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 pc_valid_i,
  input  logic [WORD-1:0]      pc_i,
  output logic [WORD-1:0]      imem_addr_o,
  input  logic [HALF_WORD-1:0] imem_rdata_i,
  output stall_pipeline_sig    stall_pipeline_o,
  input  logic                 flush_i,
  output logic                 instr_valid_o,
  output logic [HALF_WORD-1:0] instr_o,
  output logic [WORD-1:0]      instr_pc_o,
  input  logic                 decode_ready_i
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

  logic [WORD-1:0]  tag_q, tag_d;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] fifo_count;
  logic [SUM_W-1:0] outstanding;
  fetch_entry_t     fifo_head;
  fetch_entry_t     rsp_entry;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic             req_accept;
  logic             rsp_valid;

  assign imem_addr_o = pc_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

  // Only registered state feeds the stall so it never depends on decode.
  always_comb begin
    outstanding      = SUM_W'(fifo_count) + SUM_W'(inflight_q);
    stall_pipeline_o = (outstanding >= SUM_W'(DEPTH)) ? STALL_PIPELINE : NO_STALL;
  end

  always_comb begin
    req_accept = pc_valid_i && (stall_pipeline_o != STALL_PIPELINE) && !flush_i;
    rsp_valid  = inflight_q && !flush_i;
    tag_d      = req_accept ? pc_i : tag_q;
    inflight_d = req_accept;
    rsp_entry  = '{instr: imem_rdata_i, pc: tag_q};
  end

  always_comb begin
    fifo_empty    = (fifo_count == '0);
    instr_valid_o = !fifo_empty;
    instr_o       = fifo_head.instr;
    instr_pc_o    = fifo_head.pc;
    fifo_push     = rsp_valid;
    fifo_pop      = !fifo_empty && decode_ready_i;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (fifo_empty && rsp_valid) begin
      instr_valid_o = 1'b1;
      instr_o       = imem_rdata_i;
      instr_pc_o    = tag_q;
      fifo_push     = !decode_ready_i;
      fifo_pop      = 1'b0;
    end
`endif
  end

  sync_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (fifo_push),
    .data_i  (rsp_entry),
    .pop_i   (fifo_pop),
    .flush_i (flush_i),
    .head_o  (fifo_head),
    .count_o (fifo_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// +--------------------------------------------------------------------------+
// | tb_fetch_queue: scoreboard bench for fetch_queue with a behavioural      |
// | in-order model of accepted-but-undelivered fetches.                      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic                 clk = 1'b0;
  logic                 reset_i;
  logic                 pc_valid_i;
  logic [WORD-1:0]      pc_i;
  logic [WORD-1:0]      imem_addr_o;
  logic [HALF_WORD-1:0] imem_rdata_i;
  stall_pipeline_sig    stall_pipeline_o;
  logic                 flush_i;
  logic                 instr_valid_o;
  logic [HALF_WORD-1:0] instr_o;
  logic [WORD-1:0]      instr_pc_o;
  logic                 decode_ready_i;

  int              n_checks = 0;
  int              n_fail   = 0;
  int              n_deliv  = 0;
  int              base;
  logic            acc_flag = 1'b0;
  logic [WORD-1:0] sb [$];

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .pc_valid_i       (pc_valid_i),
    .pc_i             (pc_i),
    .imem_addr_o      (imem_addr_o),
    .imem_rdata_i     (imem_rdata_i),
    .stall_pipeline_o (stall_pipeline_o),
    .flush_i          (flush_i),
    .instr_valid_o    (instr_valid_o),
    .instr_o          (instr_o),
    .instr_pc_o       (instr_pc_o),
    .decode_ready_i   (decode_ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] instr_of(input logic [WORD-1:0] pc);
    return pc[15:0] ^ {pc[8:1], pc[23:16]} ^ 16'hB7E1;
  endfunction

  // Synchronous instruction memory: data one cycle after the address.
  always @(posedge clk) imem_rdata_i <= instr_of(imem_addr_o);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of PCs accepted but not yet consumed by decode.
  always @(negedge clk) begin : monitor
    logic            exp_stall;
    logic [WORD-1:0] exp_pc;
    acc_flag = 1'b0;
    if (reset_i) begin
      sb.delete();
    end else begin
      exp_stall = (sb.size() >= DEPTH);
      check("stall", 64'(stall_pipeline_o == STALL_PIPELINE), 64'(exp_stall));
      check("imem_addr", 64'(imem_addr_o), 64'(pc_i));
      if (flush_i) begin
        sb.delete();
      end else begin
        if (instr_valid_o && decode_ready_i) begin
          n_deliv++;
          check("deliver_expected", 64'(sb.size() != 0), 64'd1);
          if (sb.size() != 0) begin
            exp_pc = sb.pop_front();
            check("instr_pc", 64'(instr_pc_o), 64'(exp_pc));
            check("instr", 64'(instr_o), 64'(instr_of(exp_pc)));
          end
        end
        if (pc_valid_i && !exp_stall) begin
          sb.push_back(pc_i);
          acc_flag = 1'b1;
        end
      end
    end
  end

  // PC source: advances only when the previous cycle's request was accepted.
  task automatic step();
    @(posedge clk);
    #1;
    if (acc_flag) pc_i = pc_i + 32'd2;
  endtask

  task automatic do_reset();
    reset_i        = 1'b1;
    pc_valid_i     = 1'b0;
    flush_i        = 1'b0;
    decode_ready_i = 1'b0;
    pc_i           = '0;
    step();
    step();
    reset_i = 1'b0;
  endtask

  task automatic fill();
    pc_valid_i     = 1'b1;
    decode_ready_i = 1'b0;
    repeat (8) step();
  endtask

  initial begin
    reset_i = 1'b1; pc_valid_i = 1'b0; flush_i = 1'b0; decode_ready_i = 1'b0; pc_i = '0;

    // Streaming with decode always ready.
    do_reset();
    pc_valid_i     = 1'b1;
    decode_ready_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check("rst_valid", 64'(instr_valid_o), 64'd0);
        check("rst_instr", 64'(instr_o), 64'd0);
        check("rst_pc", 64'(instr_pc_o), 64'd0);
      end
      if (c >= LAT) begin
        check("stream_valid", 64'(instr_valid_o), 64'd1);
        check("stream_pc", 64'(instr_pc_o), 64'(2 * (c - LAT)));
      end
      step();
    end
    pc_valid_i = 1'b0;
    repeat (4) step();

    // Fill with decode blocked, then release one entry.
    do_reset();
    fill();
    @(negedge clk);
    check("full_valid", 64'(instr_valid_o), 64'd1);
    check("full_head_pc", 64'(instr_pc_o), 64'd0);
    check("full_stall", 64'(stall_pipeline_o), 64'(STALL_PIPELINE));
    check("full_pc_held", 64'(pc_i), 64'd8);
    step();
    decode_ready_i = 1'b1;
    step();
    decode_ready_i = 1'b0;
    @(negedge clk);
    check("release_stall", 64'(stall_pipeline_o), 64'(NO_STALL));
    step();
    pc_valid_i = 1'b0;
    decode_ready_i = 1'b1;
    repeat (8) step();

    // Flush with three buffered and one in flight.
    do_reset();
    fill();
    decode_ready_i = 1'b1;
    step();
    decode_ready_i = 1'b0;
    step();
    flush_i = 1'b1;
    step();
    flush_i    = 1'b0;
    pc_valid_i = 1'b0;
    @(negedge clk);
    check("flush_valid", 64'(instr_valid_o), 64'd0);
    step();
    pc_i       = 32'h40;
    pc_valid_i = 1'b1;
    base       = n_deliv;
    step();
    pc_valid_i     = 1'b0;
    decode_ready_i = 1'b1;
    repeat (5) step();
    check("flush_deliv_count", 64'(n_deliv - base), 64'd1);

    // Reset while full and stalled.
    do_reset();
    fill();
    reset_i    = 1'b1;
    pc_valid_i = 1'b0;
    step();
    reset_i = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 64'(instr_valid_o), 64'd0);
    check("mid_rst_instr", 64'(instr_o), 64'd0);
    check("mid_rst_pc", 64'(instr_pc_o), 64'd0);
    check("mid_rst_stall", 64'(stall_pipeline_o), 64'(NO_STALL));
    step();

    // Valid pattern 1,0,1.
    do_reset();
    decode_ready_i = 1'b1;
    base           = n_deliv;
    pc_valid_i = 1'b1; step();
    pc_valid_i = 1'b0; step();
    pc_valid_i = 1'b1; step();
    pc_valid_i = 1'b0;
    repeat (5) step();
    check("gap_deliv_count", 64'(n_deliv - base), 64'd2);

    // Randomised traffic with redirects.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      pc_valid_i     = ($urandom_range(0, 9) < 7);
      decode_ready_i = ($urandom_range(0, 9) < 6);
      flush_i        = ($urandom_range(0, 99) < 4);
      step();
      if (flush_i) pc_i = $urandom() & 32'hFFFF_FFFE;
    end
    pc_valid_i     = 1'b0;
    flush_i        = 1'b0;
    decode_ready_i = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    check("drain_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
